// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle RV32I controller FSM with memory timeout and sticky trap; MCTRL_PERF_EN adds perf counters
module multicycle_controller #(
    parameter int WAIT_CNT_W     = 8,
    parameter int TIMEOUT_CYCLES = 200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic        MemReq,
    output logic        MemWrite,
    output logic        AdrSrc,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ImmSrc,
    output logic [3:0]  ALUControl,
    output logic        shift,
    output logic        retire,
    output logic        trap,
    output logic [1:0]  trap_cause
`ifdef MCTRL_PERF_EN
    ,
    output logic [31:0] instret_count,
    output logic [31:0] stall_count
`endif
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // ALU encoding is {funct7[5], funct3} for the R-type operations
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;

    localparam logic [WAIT_CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_V = WAIT_CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
        S_EXECI, S_LUI, S_ALUWB, S_JALR, S_JAL, S_BRANCH, S_TRAP
    } state_e;

    state_e                state_q, state_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d, cnt_inc;
    logic                  trap_q, trap_d;
    logic [1:0]            cause_q, cause_d;

    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, shift_c, retire_c;
    logic [1:0] result_src, src_a, src_b;
    logic [3:0] alu_ctl;
    logic       waiting, timeout_hit, taken;
    logic       unused_funct7;

    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    assign cnt_inc     = (wait_cnt_q == CNT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
    assign waiting     = mem_req && !mem_ready;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && waiting && (cnt_inc >= TIMEOUT_V);
    assign taken       = Zero ^ (funct3[0] ^ funct3[2]);

    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        shift_c    = 1'b0;
        retire_c   = 1'b0;
        result_src = 2'b00;
        src_a      = 2'b00;
        src_b      = 2'b00;
        alu_ctl    = ALU_ADD;
        unique case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    src_b      = 2'b10;
                    result_src = 2'b10;
                    pc_write   = 1'b1;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                src_a = 2'b01;
                src_b = 2'b01;
                unique case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECR;
                    OP_I:              state_d = S_EXECI;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_ALUWB;
                    default: begin
                        state_d = S_TRAP;
                        cause_d = 2'b01;
                    end
                endcase
            end
            S_MEMADR: begin
                src_a   = 2'b10;
                src_b   = 2'b01;
                state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                retire_c   = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready) begin
                    retire_c = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_EXECR: begin
                src_a   = 2'b10;
                alu_ctl = {funct7[5] && (funct3 == 3'b000 || funct3 == 3'b101), funct3};
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                // funct7[5] is immediate data except for SRAI
                src_a   = 2'b10;
                src_b   = 2'b01;
                alu_ctl = {funct7[5] && (funct3 == 3'b101), funct3};
                shift_c = (funct3 == 3'b001) || (funct3 == 3'b101);
                state_d = S_ALUWB;
            end
            S_LUI: begin
                src_a   = 2'b11;
                src_b   = 2'b01;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                retire_c  = 1'b1;
                state_d   = S_FETCH;
            end
            S_JALR: begin
                src_a   = 2'b10;
                src_b   = 2'b01;
                state_d = S_JAL;
            end
            S_JAL: begin
                src_a    = 2'b01;
                src_b    = 2'b10;
                pc_write = 1'b1;
                state_d  = S_ALUWB;
            end
            S_BRANCH: begin
                src_a = 2'b10;
                unique case (funct3[2:1])
                    2'b00: alu_ctl = ALU_SUB;
                    2'b10: alu_ctl = ALU_SLT;
                    2'b11: alu_ctl = ALU_SLTU;
                    default: alu_ctl = ALU_ADD;
                endcase
                if (funct3[2:1] == 2'b01) begin
                    state_d = S_TRAP;
                    cause_d = 2'b01;
                end else begin
                    pc_write = taken;
                    retire_c = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
        if (timeout_hit) begin
            state_d = S_TRAP;
            cause_d = 2'b10;
        end
    end

    assign trap_d = (state_d == S_TRAP);

    always_comb begin
        if (state_d != state_q || (mem_req && mem_ready)) begin
            wait_cnt_d = '0;
        end else if (waiting) begin
            wait_cnt_d = cnt_inc;
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
            trap_q     <= 1'b0;
            cause_q    <= 2'b00;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            trap_q     <= trap_d;
            cause_q    <= cause_d;
        end
    end

    always_comb begin
        unique case (op)
            OP_STORE:         ImmSrc = 3'b001;
            OP_BRANCH:        ImmSrc = 3'b010;
            OP_LUI, OP_AUIPC: ImmSrc = 3'b011;
            OP_JAL:           ImmSrc = 3'b100;
            default:          ImmSrc = 3'b000;
        endcase
    end

    assign MemReq     = rst_n && mem_req;
    assign MemWrite   = rst_n && mem_write;
    assign AdrSrc     = rst_n && adr_src;
    assign IRWrite    = rst_n && ir_write;
    assign PCWrite    = rst_n && pc_write;
    assign RegWrite   = rst_n && reg_write;
    assign shift      = rst_n && shift_c;
    assign retire     = rst_n && retire_c;
    assign trap       = rst_n && trap_q;
    assign ResultSrc  = rst_n ? result_src : 2'b00;
    assign ALUSrcA    = rst_n ? src_a : 2'b00;
    assign ALUSrcB    = rst_n ? src_b : 2'b00;
    assign ALUControl = rst_n ? alu_ctl : 4'b0000;
    assign trap_cause = rst_n ? cause_q : 2'b00;

`ifdef MCTRL_PERF_EN
    logic [31:0] instret_q, stall_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instret_q <= '0;
            stall_q   <= '0;
        end else if (state_q != S_TRAP) begin
            if (retire_c) instret_q <= instret_q + 32'd1;
            if (waiting)  stall_q   <= stall_q + 32'd1;
        end
    end

    assign instret_count = rst_n ? instret_q : 32'd0;
    assign stall_count   = rst_n ? stall_q : 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - randomized instruction-level bench for multicycle_controller
module tb_multicycle_controller;
    localparam int TMO = 4;

    localparam int K_R = 0, K_I = 1, K_LOAD = 2, K_STORE = 3, K_JAL = 4, K_JALR = 5;
    localparam int K_BR = 6, K_LUI = 7, K_AUIPC = 8, K_ILL = 9, K_ABORT = 10;

    localparam logic [3:0] A_ADD = 4'h0, A_SUB = 4'h8, A_SLL = 4'h1, A_SLT = 4'h2;
    localparam logic [3:0] A_SLTU = 4'h3, A_XOR = 4'h4, A_SRL = 4'h5, A_SRA = 4'hd;
    localparam logic [3:0] A_OR = 4'h6, A_AND = 4'h7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic [6:0] funct7 = 7'd0;
    logic       Zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, shift, retire, trap;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, trap_cause;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;
`ifdef MCTRL_PERF_EN
    logic [31:0] instret_count, stall_count;
`endif

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] m_inst = 0;
    logic [31:0] m_stall = 0;

    multicycle_controller #(.WAIT_CNT_W(8), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7(funct7),
        .Zero(Zero), .mem_ready(mem_ready), .MemReq(MemReq), .MemWrite(MemWrite),
        .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .shift(shift), .retire(retire), .trap(trap),
        .trap_cause(trap_cause)
`ifdef MCTRL_PERF_EN
        , .instret_count(instret_count), .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    logic [23:0] obs;
    assign obs = {MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ResultSrc, ALUSrcA,
                  ALUSrcB, ImmSrc, ALUControl, shift, retire, trap, trap_cause};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic logic [6:0] opcode_of(input int k);
        case (k)
            K_R:     return 7'b0110011;
            K_I:     return 7'b0010011;
            K_LOAD:  return 7'b0000011;
            K_STORE: return 7'b0100011;
            K_JAL:   return 7'b1101111;
            K_JALR:  return 7'b1100111;
            K_BR:    return 7'b1100011;
            K_LUI:   return 7'b0110111;
            K_AUIPC: return 7'b0010111;
            default: return 7'b0110011;
        endcase
    endfunction

    function automatic bit is_legal_op(input logic [6:0] o);
        for (int k = 0; k < K_ILL; k++) if (opcode_of(k) == o) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [2:0] imm_of(input logic [6:0] o);
        if (o == opcode_of(K_STORE)) return 3'b001;
        if (o == opcode_of(K_BR)) return 3'b010;
        if (o == opcode_of(K_LUI) || o == opcode_of(K_AUIPC)) return 3'b011;
        if (o == opcode_of(K_JAL)) return 3'b100;
        return 3'b000;
    endfunction

    function automatic logic [3:0] r_alu(input logic [2:0] f3, input logic alt, input bit imm);
        case (f3)
            3'd0: return (alt && !imm) ? A_SUB : A_ADD;
            3'd1: return A_SLL;
            3'd2: return A_SLT;
            3'd3: return A_SLTU;
            3'd4: return A_XOR;
            3'd5: return alt ? A_SRA : A_SRL;
            3'd6: return A_OR;
            default: return A_AND;
        endcase
    endfunction

    function automatic logic [23:0] ev(input logic mreq, input logic mw, input logic adr,
                                       input logic irw, input logic pcw, input logic rw,
                                       input logic [1:0] rs, input logic [1:0] sa,
                                       input logic [1:0] sb, input logic [3:0] alu,
                                       input logic sh, input logic ret);
        return {mreq, mw, adr, irw, pcw, rw, rs, sa, sb, imm_of(op), alu, sh, ret, 3'b000};
    endfunction

    function automatic logic [23:0] ev_trap(input logic [1:0] cause);
        return {12'b0, imm_of(op), 4'b0, 2'b0, 1'b1, cause};
    endfunction

    task automatic step(input string tag, input logic [23:0] e);
        @(negedge clk);
        check_eq(tag, 32'(obs), 32'(e));
        if (e[23] && !mem_ready) m_stall++;
        if (e[3]) m_inst++;
        @(posedge clk);
        #1;
`ifdef MCTRL_PERF_EN
        check_eq({tag, "/instret"}, instret_count, m_inst);
        check_eq({tag, "/stall"}, stall_count, m_stall);
`endif
    endtask

    task automatic idle(input string tag, input logic [23:0] e);
        mem_ready = 1'($urandom);
        Zero      = 1'($urandom);
        step(tag, e);
    endtask

    task automatic mem_phase(input string tag, input int waits, input logic [23:0] e_wait,
                             input logic [23:0] e_done, output bit timed_out);
        timed_out = 1'b0;
        for (int i = 0; i < waits && i < TMO; i++) begin
            mem_ready = 1'b0;
            step(tag, e_wait);
        end
        if (waits >= TMO) timed_out = 1'b1;
        else begin
            mem_ready = 1'b1;
            step(tag, e_done);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mem_ready = 1'($urandom);
            @(negedge clk);
            check_eq("reset", 32'(obs), 32'({12'b0, imm_of(op), 9'b0}));
            @(posedge clk);
            #1;
        end
        rst_n   = 1'b1;
        m_inst  = 0;
        m_stall = 0;
    endtask

    task automatic trap_hold(input int n, input logic [1:0] cause);
        for (int i = 0; i < n; i++) idle("trap", ev_trap(cause));
        do_reset();
    endtask

    task automatic do_instr(input int k, input logic [2:0] f3, input logic alt,
                            input logic z, input int wf, input int wm);
        bit          to;
        logic [23:0] e_wb, e_addr;
        if (k == K_ILL) begin
            do op = 7'($urandom); while (is_legal_op(op));
        end else begin
            op = opcode_of(k);
        end
        funct3    = f3;
        funct7    = 7'($urandom);
        funct7[5] = alt;
        e_wb   = ev(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, A_ADD, 0, 1);
        e_addr = ev(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, A_ADD, 0, 0);
        mem_phase("fetch", wf, ev(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, A_ADD, 0, 0),
                  ev(1, 0, 0, 1, 1, 0, 2'b10, 2'b00, 2'b10, A_ADD, 0, 0), to);
        if (to) begin
            trap_hold(3, 2'b10);
            return;
        end
        idle("decode", ev(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, A_ADD, 0, 0));
        case (k)
            K_R: begin
                idle("execr", ev(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, r_alu(f3, alt, 0), 0, 0));
                idle("aluwb", e_wb);
            end
            K_I: begin
                idle("execi", ev(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, r_alu(f3, alt, 1),
                                 f3 == 3'd1 || f3 == 3'd5, 0));
                idle("aluwb", e_wb);
            end
            K_LOAD: begin
                idle("memadr", e_addr);
                mem_phase("memread", wm, ev(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, A_ADD, 0, 0),
                          ev(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, A_ADD, 0, 0), to);
                if (to) trap_hold(3, 2'b10);
                else idle("memwb", ev(0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, A_ADD, 0, 1));
            end
            K_STORE: begin
                idle("memadr", e_addr);
                mem_phase("memwrite", wm, ev(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, A_ADD, 0, 0),
                          ev(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, A_ADD, 0, 1), to);
                if (to) trap_hold(3, 2'b10);
            end
            K_JAL, K_JALR: begin
                if (k == K_JALR) idle("jalr", e_addr);
                idle("jal", ev(0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 2'b10, A_ADD, 0, 0));
                idle("aluwb", e_wb);
            end
            K_BR: begin
                mem_ready = 1'($urandom);
                Zero      = z;
                if (f3 == 3'd2 || f3 == 3'd3) begin
                    step("br_illegal", ev(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, A_ADD, 0, 0));
                    trap_hold(3, 2'b01);
                end else begin
                    // BEQ/BGE/BGEU branch on a zero ALU result, the others on non-zero
                    step("branch", ev(0, 0, 0, 0, (f3 == 0 || f3 == 5 || f3 == 7) ? z : !z, 0,
                                      2'b00, 2'b10, 2'b00,
                                      (f3 < 2) ? A_SUB : (f3 < 6) ? A_SLT : A_SLTU, 0, 1));
                end
            end
            K_LUI: begin
                idle("lui", ev(0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b01, A_ADD, 0, 0));
                idle("aluwb", e_wb);
            end
            K_AUIPC: idle("aluwb", e_wb);
            K_ILL:   trap_hold(10, 2'b01);
            default: do_reset();
        endcase
    endtask

    initial begin
        int k, wf, wm;
        do_reset();
        do_instr(K_R, 3'd0, 1'b0, 1'b0, 0, 0);
        do_instr(K_LOAD, 3'd2, 1'b0, 1'b0, 0, 3);
        do_instr(K_BR, 3'd1, 1'b0, 1'b0, 0, 0);
        do_instr(K_BR, 3'd5, 1'b0, 1'b0, 0, 0);
        do_instr(K_BR, 3'd6, 1'b0, 1'b1, 0, 0);
        op = 7'd0;
        funct3 = 3'd0;
        mem_phase("fetch", 0, ev(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, A_ADD, 0, 0),
                  ev(1, 0, 0, 1, 1, 0, 2'b10, 2'b00, 2'b10, A_ADD, 0, 0), wf[0]);
        idle("decode", ev(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, A_ADD, 0, 0));
        trap_hold(11, 2'b01);
        do_instr(K_R, 3'd0, 1'b0, 1'b0, TMO, 0);
        do_instr(K_I, 3'd5, 1'b1, 1'b0, 3, 0);
        do_instr(K_STORE, 3'd2, 1'b0, 1'b0, 1, 2);
        do_instr(K_JALR, 3'd0, 1'b0, 1'b0, 0, 0);
        do_instr(K_LOAD, 3'd2, 1'b0, 1'b0, 0, TMO);
        do_reset();
        do_instr(K_R, 3'd0, 1'b1, 1'b0, 1, 0);
        do_instr(K_I, 3'd0, 1'b1, 1'b0, 0, 0);
        do_instr(K_LOAD, 3'd2, 1'b0, 1'b0, 0, 1);
`ifdef MCTRL_PERF_EN
        check_eq("perf_instret3", instret_count, 32'd3);
        check_eq("perf_stall2", stall_count, 32'd2);
`endif
        for (int n = 0; n < 300; n++) begin
            k = $urandom_range(0, 10);
            if ((k == K_ILL || k == K_ABORT) && ($urandom_range(0, 3) != 0)) k = K_R;
            wf = ($urandom_range(0, 19) == 0) ? TMO : $urandom_range(0, 3);
            wm = ($urandom_range(0, 19) == 0) ? TMO : $urandom_range(0, 3);
            do_instr(k, 3'($urandom), 1'($urandom), 1'($urandom), wf, wm);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
